// File: rtl/sram_arbiter_pkg.sv
// Shared configuration for the two-master SRAM arbiter: state encodings,
// reset constants and the contention tie-break helper.
package sram_arbiter_pkg;

    localparam int STATE_W = 2;
    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    // last_grant resets to master 1 so that master 0 wins the first contention.
    localparam logic LAST_GRANT_RST = 1'b1;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 2'b00,
        ST_GRANT0 = 2'b01,
        ST_GRANT1 = 2'b10
    } state_e;

    // Returns the index of the master to grant from IDLE; only meaningful when
    // at least one request is present.
    function automatic logic pick_winner(input logic req0, input logic req1,
                                         input logic last_grant);
        logic winner;
        winner = 1'b0;
        if (req0 && !req1) begin
            winner = 1'b0;
        end else if (req1 && !req0) begin
            winner = 1'b1;
        end else begin
            winner = ~last_grant;
        end
        return winner;
    endfunction

endpackage

// File: rtl/sram_arbiter_regular_register.sv
// Plain D register with asynchronous active-high reset to a parameterised
// value; holds the arbiter's state and last_grant bits.
module sram_arbiter_regular_register #(
    parameter int              SIZE      = 1,
    parameter logic [SIZE-1:0] RESET_VAL = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [SIZE-1:0] d,
    output logic [SIZE-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= RESET_VAL;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Two-master round-robin arbiter in front of a single SRAM port. A granted
// master drives the SRAM combinationally until sram_ready or it withdraws.
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [ADDR_W-1:0] m0_address,
    input  logic [DATA_W-1:0] m0_write_data,
    input  logic              m0_read_en,
    input  logic              m0_write_en,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_ready,

    input  logic [ADDR_W-1:0] m1_address,
    input  logic [DATA_W-1:0] m1_write_data,
    input  logic              m1_read_en,
    input  logic              m1_write_en,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_ready,

    output logic [ADDR_W-1:0] sram_address,
    output logic [DATA_W-1:0] sram_write_data,
    output logic              sram_read_en,
    output logic              sram_write_en,
    input  logic [DATA_W-1:0] sram_read_data,
    input  logic              sram_ready,

    output logic [STATE_W-1:0] state_dbg,
    output logic               last_grant_dbg
);

    // Handshake: a master holds read_en/write_en (and address/data) stable
    // until it sees mN_ready high with its request still asserted; that single
    // cycle is the completion cycle and the only one in which mN_rdata is valid.

    logic               req0;
    logic               req1;
    logic               winner;
    state_e             state_q;
    state_e             state_d;
    logic [STATE_W-1:0] state_q_raw;
    logic               last_grant_q;
    logic               last_grant_d;

    assign req0 = m0_read_en | m0_write_en;
    assign req1 = m1_read_en | m1_write_en;

    sram_arbiter_regular_register #(
        .SIZE      (STATE_W),
        .RESET_VAL (ST_IDLE)
    ) u_state_reg (
        .clk (clk),
        .rst (rst),
        .d   (state_d),
        .q   (state_q_raw)
    );

    sram_arbiter_regular_register #(
        .SIZE      (1),
        .RESET_VAL (LAST_GRANT_RST)
    ) u_last_grant_reg (
        .clk (clk),
        .rst (rst),
        .d   (last_grant_d),
        .q   (last_grant_q)
    );

    assign state_q        = state_e'(state_q_raw);
    assign state_dbg      = state_q_raw;
    assign last_grant_dbg = last_grant_q;

    // Next state. Every grant falls back to IDLE, which enforces one idle
    // cycle between grants and makes back-to-back requests re-arbitrate.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        winner       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req0 || req1) begin
                    winner       = pick_winner(req0, req1, last_grant_q);
                    state_d      = winner ? ST_GRANT1 : ST_GRANT0;
                    last_grant_d = winner;
                end
            end
            ST_GRANT0: begin
                if (sram_ready || !req0) begin
                    state_d = ST_IDLE;
                end
            end
            ST_GRANT1: begin
                if (sram_ready || !req1) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // SRAM port mux and master responses. Write wins when both enables are set.
    always_comb begin
        sram_address    = '0;
        sram_write_data = '0;
        sram_read_en    = 1'b0;
        sram_write_en   = 1'b0;
        m0_rdata        = '0;
        m1_rdata        = '0;
        m0_ready        = ~req0;
        m1_ready        = ~req1;
        case (state_q)
            ST_GRANT0: begin
                sram_address    = m0_address;
                sram_write_data = m0_write_data;
                sram_write_en   = m0_write_en;
                sram_read_en    = m0_read_en & ~m0_write_en;
                if (sram_ready && req0) begin
                    m0_ready = 1'b1;
                    if (!m0_write_en) begin
                        m0_rdata = sram_read_data;
                    end
                end
            end
            ST_GRANT1: begin
                sram_address    = m1_address;
                sram_write_data = m1_write_data;
                sram_write_en   = m1_write_en;
                sram_read_en    = m1_read_en & ~m1_write_en;
                if (sram_ready && req1) begin
                    m1_ready = 1'b1;
                    if (!m1_write_en) begin
                        m1_rdata = sram_read_data;
                    end
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, SHALL set the address width of both master ports and the SRAM port.
REQ-002 Parameter DATA_W, default 32, SHALL set the data width of both master ports and the SRAM port.
REQ-003 clk  input  1  SHALL be the single clock; all state changes occur on its rising edge.
REQ-004 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 Each master port N (N=0,1) SHALL have these signals:
- mN_address  input  ADDR_W  request address.
- mN_write_data  input  DATA_W  write data.
- mN_read_en  input  1  read request, held until mN_ready.
- mN_write_en  input  1  write request, held until mN_ready.
- mN_rdata  output  DATA_W  read data, valid only in the mN_ready completion cycle.
- mN_ready  output  1  low while a request of master N is pending; high otherwise.
REQ-006 The SRAM port SHALL have these signals:
- sram_address  output  ADDR_W  address to SRAM.
- sram_write_data  output  DATA_W  write data to SRAM.
- sram_read_en  output  1  SRAM read strobe.
- sram_write_en  output  1  SRAM write strobe.
- sram_read_data  input  DATA_W  SRAM read data.
- sram_ready  input  1  SRAM access complete this cycle.

Function
REQ-007 reqN SHALL be defined as mN_read_en OR mN_write_en. If both enables are high, the access SHALL be treated as a write.
REQ-008 The FSM SHALL have three states, IDLE, GRANT0 and GRANT1, with the following transitions:
- IDLE to GRANTN when reqN is high and the other master is not requesting.
- IDLE to GRANTN for the master selected by REQ-009 when both are requesting.
- GRANTN to IDLE when sram_ready is high or reqN falls.
REQ-009 When both masters request in IDLE, the master not recorded in the 1-bit last_grant register SHALL be granted. last_grant SHALL update on every IDLE-to-GRANTN transition.
REQ-010 In GRANTN, the SRAM outputs SHALL combinationally follow master N: address, write data, read_en and write_en.
REQ-011 In IDLE, all SRAM outputs SHALL be 0.
REQ-012 mN_ready SHALL be:
- 1 when reqN is low;
- 0 when reqN is high, except in the GRANTN cycle with sram_ready high, where it SHALL be 1 for exactly that cycle.
REQ-013 mN_rdata SHALL equal sram_read_data in the GRANTN read completion cycle, and 0 otherwise.
REQ-014 After every grant there SHALL be exactly one IDLE cycle before the next grant. Minimum latency from request to grant is 1 cycle.
REQ-015 A master SHALL wait at most one other master's transaction before being granted (no starvation).
REQ-016 If reqN drops during GRANTN without sram_ready, the access SHALL be abandoned: return to IDLE, no ready pulse, last_grant unchanged from its grant-time value.
REQ-017 sram_ready arriving in IDLE SHALL be ignored.
REQ-018 A back-to-back request from the same master (e.g. the second word of a line fill) SHALL re-arbitrate in IDLE like any new request.

Reset
REQ-019 On rst, the FSM SHALL go to IDLE and last_grant SHALL be set to 1, so that master 0 wins the first contention.
REQ-020 During and after reset, all SRAM outputs and mN_rdata SHALL be 0, and mN_ready SHALL follow REQ-012.
REQ-021 A reset asserted mid-grant SHALL abort the access immediately and asynchronously; no ready pulse SHALL be produced.

Structure
REQ-022 The state encodings (IDLE=2'b00, GRANT0=2'b01, GRANT1=2'b10) SHALL be defined in the shared configs include, alongside the existing configuration constants.
REQ-023 The state register and last_grant register SHALL be instances of the existing Regular_Register sub-module (SIZE 2 and SIZE 1). No other sub-module is required.

Verification
REQ-024 Solo read: m0_read_en=1, m0_address=0x400; sram_ready asserted 3 cycles after grant with sram_read_data=0xDEADBEEF. Required: m0_ready is high for one cycle, m0_rdata=0xDEADBEEF, and the FSM returns to IDLE.
REQ-025 Contention after reset: m0_read_en and m1_write_en are raised in the same cycle. Required: m0 is granted first; m1 (address 0x800, data 0x12345678) is granted after one IDLE cycle; the SRAM sees sram_write_en=1 with those values.
REQ-026 Fairness: both masters request continuously for 8 transactions. Required: grants alternate 0,1,0,1..., and each master completes exactly 4 transactions.
REQ-027 Withdrawal: m1 is granted, then m1_write_en drops before sram_ready. Required: the FSM returns to IDLE, m1_ready gives no pulse, and a pending m0 request is granted next.
REQ-028 Reset mid-grant: rst is asserted in GRANT0 while sram_ready=0. Required: all SRAM enables are 0 immediately; after reset is released, m0 wins the next contention.
REQ-029 Both enables: m0_read_en=m0_write_en=1. Required: sram_write_en=1, sram_read_en=0, and m0_rdata=0 at completion.
